// File: rtl/read_fifo_side.sv
// Read-domain control of an asynchronous FIFO: read pointer, write-pointer
// synchroniser, empty flag, occupancy, read-valid strobe and sticky underflow.
module read_fifo_side #(
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  r_clk_in,
   input  logic                  r_reset_n_in,
   input  logic                  r_request_in,
   input  logic [ADDR_WIDTH:0]   w_gray_ptr_in,
   output logic                  r_empty_out,
   output logic [ADDR_WIDTH-1:0] r_addr_out,
   output logic [ADDR_WIDTH:0]   r_gray_ptr_out,
   output logic                  r_valid_out,
   output logic [ADDR_WIDTH:0]   r_count_out,
   output logic                  r_underflow_out
);

   logic [ADDR_WIDTH:0] r_bin_reg;
   logic [ADDR_WIDTH:0] r_bin_next;
   logic [ADDR_WIDTH:0] r_gray_next;
   logic [ADDR_WIDTH:0] wq1_reg;
   logic [ADDR_WIDTH:0] wq2_reg;
   logic [ADDR_WIDTH:0] wq2_bin;
   logic                accept;

   // Accept is judged against the registered flag only, so a read that
   // empties the FIFO blocks a request in the very next cycle.
   assign accept      = r_request_in & ~r_empty_out;
   assign r_bin_next  = r_bin_reg + {{ADDR_WIDTH{1'b0}}, accept};
   assign r_gray_next = r_bin_next ^ (r_bin_next >> 1);
   assign r_addr_out  = r_bin_reg[ADDR_WIDTH-1:0];

   // Gray to binary: each bit is the XOR of itself and all higher bits.
   genvar gi;
   generate
      for (gi = 0; gi <= ADDR_WIDTH; gi++) begin : g_gray2bin
         assign wq2_bin[gi] = ^wq2_reg[ADDR_WIDTH:gi];
      end
   endgenerate

   always_ff @(posedge r_clk_in) begin
      if (!r_reset_n_in) begin
         wq1_reg         <= '0;
         wq2_reg         <= '0;
         r_bin_reg       <= '0;
         r_gray_ptr_out  <= '0;
         r_empty_out     <= 1'b1;
         r_count_out     <= '0;
         r_valid_out     <= 1'b0;
         r_underflow_out <= 1'b0;
      end else begin
         wq1_reg         <= w_gray_ptr_in;
         wq2_reg         <= wq1_reg;
         r_bin_reg       <= r_bin_next;
         r_gray_ptr_out  <= r_gray_next;
         // Full-width compare keeps the wrap bit, so full never looks empty.
         r_empty_out     <= (r_gray_next == wq2_reg);
         r_count_out     <= wq2_bin - r_bin_next;
         r_valid_out     <= accept;
         r_underflow_out <= r_underflow_out | (r_request_in & r_empty_out);
      end
   end

endmodule

// File: tb/tb_read_fifo_side.sv
// Directed bench for read_fifo_side: per-cycle flag checks plus a scoreboard
// that matches every r_valid_out pulse against the address expected to be read.
module tb_read_fifo_side;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          r_reset_n_in;
   logic          r_request_in;
   logic [AW:0]   w_gray_ptr_in;
   logic          r_empty_out;
   logic [AW-1:0] r_addr_out;
   logic [AW:0]   r_gray_ptr_out;
   logic          r_valid_out;
   logic [AW:0]   r_count_out;
   logic          r_underflow_out;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   logic [AW-1:0] prev_addr;

   always #5 clk = ~clk;

   read_fifo_side #(.ADDR_WIDTH(AW)) dut (
      .r_clk_in        (clk),
      .r_reset_n_in    (r_reset_n_in),
      .r_request_in    (r_request_in),
      .w_gray_ptr_in   (w_gray_ptr_in),
      .r_empty_out     (r_empty_out),
      .r_addr_out      (r_addr_out),
      .r_gray_ptr_out  (r_gray_ptr_out),
      .r_valid_out     (r_valid_out),
      .r_count_out     (r_count_out),
      .r_underflow_out (r_underflow_out)
   );

   function automatic int gray(int b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(string name, logic [31:0] act, int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Negative expected value means "don't care" for that output.
   task automatic expect_out(string tag, int e_empty, int e_addr, int e_gray,
                             int e_count, int e_valid, int e_uf);
      if (e_empty >= 0) check({tag, ".empty"},     {31'd0, r_empty_out},     e_empty);
      if (e_addr  >= 0) check({tag, ".addr"},      {29'd0, r_addr_out},      e_addr);
      if (e_gray  >= 0) check({tag, ".gray"},      {28'd0, r_gray_ptr_out},  e_gray);
      if (e_count >= 0) check({tag, ".count"},     {28'd0, r_count_out},     e_count);
      if (e_valid >= 0) check({tag, ".valid"},     {31'd0, r_valid_out},     e_valid);
      if (e_uf    >= 0) check({tag, ".underflow"}, {31'd0, r_underflow_out}, e_uf);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a valid pulse carries data for the address presented one cycle earlier.
   initial begin
      forever begin
         @(negedge clk);
         if (r_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL valid_unexpected: got valid for addr %0d expected no read", prev_addr);
            end else begin
               int e;
               e = exp_q.pop_front();
               check("valid_addr", {29'd0, prev_addr}, e);
            end
         end
         prev_addr = r_addr_out;
      end
   end

   initial begin
      r_reset_n_in  = 1'b0;
      r_request_in  = 1'b1;
      w_gray_ptr_in = 4'd5;
      repeat (3) begin
         tick();
         expect_out("reset", 1, 0, 0, 0, 0, 0);
      end

      // Write visibility: empty falls two edges after the first new sample.
      r_reset_n_in = 1'b1; r_request_in = 1'b0; w_gray_ptr_in = 4'd0;
      tick();
      w_gray_ptr_in = 4'd1; tick(); expect_out("vis0", 1, 0, 0, 0, 0, 0);
      w_gray_ptr_in = 4'd3; tick(); expect_out("vis1", 1, 0, 0, 0, 0, 0);
      w_gray_ptr_in = 4'd2; tick(); expect_out("vis2", 0, 0, 0, 1, 0, 0);
      tick(); expect_out("vis3", 0, 0, 0, 2, 0, 0);
      tick(); expect_out("vis4", 0, 0, 0, 3, 0, 0);

      // Drain three entries, then two requests while empty.
      for (int k = 1; k <= 5; k++) begin
         int m;
         m = (k < 3) ? k : 3;
         r_request_in = 1'b1;
         if (k <= 3) exp_q.push_back(k - 1);
         tick();
         expect_out("drain", (k >= 3) ? 1 : 0, m, gray(m), 3 - m,
                    (k <= 3) ? 1 : 0, (k >= 4) ? 1 : 0);
      end
      r_request_in = 1'b0;

      // Reset, then full view with write pointer 8.
      r_reset_n_in = 1'b0; tick();
      expect_out("reset2", 1, 0, 0, 0, 0, 0);
      r_reset_n_in = 1'b1; w_gray_ptr_in = 4'd12;
      repeat (3) tick();
      expect_out("full", 0, 0, 0, 8, 0, 0);

      for (int k = 1; k <= 8; k++) begin
         r_request_in = 1'b1;
         exp_q.push_back(k - 1);
         tick();
         expect_out("wrap", (k == 8) ? 1 : 0, k % 8, gray(k), 8 - k, 1, 0);
      end
      r_request_in = 1'b0;

      // Refill to 12 and read 4 across the wrapped pointer.
      w_gray_ptr_in = 4'd10;
      repeat (3) tick();
      expect_out("refill", 0, 0, 12, 4, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         r_request_in = 1'b1;
         exp_q.push_back(k - 1);
         tick();
         expect_out("reread", (k == 4) ? 1 : 0, k, gray(8 + k), 4 - k, 1, 0);
      end

      // Request while empty: no pointer move, no valid, underflow sticks.
      tick();
      expect_out("under", 1, 4, 10, 0, 0, 1);
      r_request_in = 1'b0;

      w_gray_ptr_in = 4'd11;
      repeat (3) tick();
      expect_out("pre_rst", 0, 4, 10, 1, 0, 1);
      r_request_in = 1'b1;
      exp_q.push_back(4);
      tick();
      expect_out("pre_rst_rd", 1, 5, 11, 0, 1, 1);

      // Mid-stream reset for a single edge.
      r_reset_n_in = 1'b0;
      tick();
      expect_out("mid_rst", 1, 0, 0, 0, 0, 0);
      r_reset_n_in = 1'b1; r_request_in = 1'b0; w_gray_ptr_in = 4'd3;
      repeat (3) tick();
      expect_out("resume", 0, 0, 0, 2, 0, 0);
      r_request_in = 1'b1;
      exp_q.push_back(0);
      tick();
      expect_out("resume_rd", 0, 1, 1, 1, 1, 0);
      r_request_in = 1'b0;
      tick();
      tick();
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
